// File: rtl/frame_wr_pkg.sv
// Shared types and constants for the camera-to-DDR3 frame writer.
// Imported by the writer top level and its pixel packer.
package frame_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_CMD,
    ST_DATA
  } wr_state_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam int         NUM_BUFS  = 3;
  localparam int         PIX_W     = 16;
  localparam int         WORD_W    = 128;
  localparam int         LANES     = WORD_W / PIX_W;

  // Frame buffers rotate 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_buf(input logic [1:0] b);
    return (b == 2'(NUM_BUFS - 1)) ? 2'd0 : b + 2'd1;
  endfunction

endpackage

// File: rtl/pixel_packer_16to128.sv
// Packs eight 16-bit pixels into one 128-bit word, pixel 0 in the LSBs.
// A clear restarts the word; a pixel arriving with clear becomes lane 0.
module pixel_packer_16to128
  import frame_wr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              pix_en,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              lane_full,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [2:0]                   lane;
  logic [2:0]                   eff_lane;
  logic [PIX_W*(LANES-1)-1:0]   data_r;

  assign eff_lane   = clr ? 3'd0 : lane;
  assign lane_full  = (lane == 3'(LANES - 1));
  assign word_valid = pix_en && !clr && lane_full;
  // The eighth pixel is merged on the fly so the word is ready on its accept edge.
  assign word_data  = {pix_data, data_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= 3'd0;
    end else if (pix_en) begin
      lane <= eff_lane + 3'd1;
    end else if (clr) begin
      lane <= 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (eff_lane == 3'(k)) data_r[k*PIX_W +: PIX_W] <= pix_data;
      end
    end
  end

endmodule

// File: rtl/cmos_frame_writer.sv
// Write-side frame DMA: packs camera pixels into bursts and writes them to
// three rotating DDR3 frame buffers, publishing the last completed buffer.
module cmos_frame_writer
  import frame_wr_pkg::*;
#(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int BURST_WORDS = 16,
  parameter int ADDR_WIDTH  = 28,
  parameter int FRAME_SHIFT = 21
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_calib_done,
  input  logic                  I_pix_valid,
  input  logic [PIX_W-1:0]      I_pix_data,
  input  logic                  I_pix_sof,
  output logic                  O_pix_ready,
  input  logic                  I_cmd_ready,
  output logic [2:0]            O_cmd,
  output logic                  O_cmd_en,
  output logic [ADDR_WIDTH-1:0] O_addr,
  output logic [5:0]            O_app_burst_number,
  input  logic                  I_wr_data_rdy,
  output logic [WORD_W-1:0]     O_wr_data,
  output logic                  O_wr_data_en,
  output logic                  O_wr_data_end,
  output logic [15:0]           O_wr_data_mask,
  output logic                  O_frame_done,
  output logic [1:0]            O_last_frame,
  output logic                  O_frame_err
);

  localparam int BURSTS    = H_RES * V_RES / (LANES * BURST_WORDS);
  localparam int BIDX_W    = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int PTR_W     = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int OFF_SHIFT = $clog2(BURST_WORDS * LANES);
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(BURST_WORDS - 1);
  localparam logic [BIDX_W-1:0] LAST_BURST = BIDX_W'(BURSTS - 1);

  wr_state_e             state, state_n;
  logic [1:0]            cur_buf, cur_buf_n, last_frame_n;
  logic [BIDX_W-1:0]     burst_idx, burst_idx_n;
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [ADDR_WIDTH-1:0] addr_n, base_addr, burst_off;
  logic                  pix_acc, pk_clr, pk_en;
  logic                  lane_full, word_valid;
  logic [WORD_W-1:0]     word_data;
  logic                  frame_done_n, frame_err_n;

  logic [WORD_W-1:0]     burst_mem [BURST_WORDS];

  assign O_cmd              = CMD_WRITE;
  assign O_app_burst_number = 6'(BURST_WORDS - 1);
  assign O_wr_data_mask     = '0;

  assign pix_acc   = I_pix_valid && O_pix_ready;
  assign base_addr = ADDR_WIDTH'(cur_buf) << FRAME_SHIFT;
  assign burst_off = ADDR_WIDTH'(burst_idx) << OFF_SHIFT;

  pixel_packer_16to128 u_packer (
    .clk        (I_clk),
    .rst        (I_rst),
    .clr        (pk_clr),
    .pix_en     (pk_en),
    .pix_data   (I_pix_data),
    .lane_full  (lane_full),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_n      = state;
    cur_buf_n    = cur_buf;
    burst_idx_n  = burst_idx;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    addr_n       = O_addr;
    last_frame_n = O_last_frame;
    pk_clr       = 1'b0;
    pk_en        = 1'b0;
    frame_done_n = 1'b0;
    frame_err_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pix_acc && I_pix_sof && I_calib_done) begin
          state_n     = ST_FILL;
          pk_clr      = 1'b1;
          pk_en       = 1'b1;
          burst_idx_n = '0;
          wr_ptr_n    = '0;
        end
      end
      ST_FILL: begin
        if (!I_calib_done) begin
          state_n = ST_IDLE;
        end else if (pix_acc) begin
          pk_en = 1'b1;
          if (I_pix_sof) begin
            // Early SOF: drop the partial burst and restart in the next buffer.
            pk_clr      = 1'b1;
            frame_err_n = 1'b1;
            cur_buf_n   = next_buf(cur_buf);
            burst_idx_n = '0;
            wr_ptr_n    = '0;
          end else if (lane_full) begin
            if (wr_ptr == LAST_PTR) begin
              wr_ptr_n = '0;
              rd_ptr_n = '0;
              addr_n   = base_addr + burst_off;
              state_n  = ST_CMD;
            end else begin
              wr_ptr_n = wr_ptr + 1'b1;
            end
          end
        end
      end
      ST_CMD: begin
        if (O_cmd_en && I_cmd_ready) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (O_wr_data_en && I_wr_data_rdy) begin
          if (rd_ptr == LAST_PTR) begin
            rd_ptr_n = '0;
            if (burst_idx == LAST_BURST) begin
              state_n      = ST_IDLE;
              frame_done_n = 1'b1;
              last_frame_n = cur_buf;
              cur_buf_n    = next_buf(cur_buf);
              burst_idx_n  = '0;
            end else begin
              burst_idx_n = burst_idx + 1'b1;
              state_n     = I_calib_done ? ST_FILL : ST_IDLE;
            end
          end else begin
            rd_ptr_n = rd_ptr + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state         <= ST_IDLE;
      cur_buf       <= 2'd0;
      burst_idx     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      O_pix_ready   <= 1'b0;
      O_cmd_en      <= 1'b0;
      O_addr        <= '0;
      O_wr_data_en  <= 1'b0;
      O_wr_data_end <= 1'b0;
      O_frame_done  <= 1'b0;
      O_frame_err   <= 1'b0;
      O_last_frame  <= 2'd2;
    end else begin
      state         <= state_n;
      cur_buf       <= cur_buf_n;
      burst_idx     <= burst_idx_n;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      O_pix_ready   <= (state_n == ST_IDLE) || (state_n == ST_FILL);
      O_cmd_en      <= (state_n == ST_CMD);
      O_addr        <= addr_n;
      O_wr_data_en  <= (state_n == ST_DATA);
      O_wr_data_end <= (state_n == ST_DATA) && (rd_ptr_n == LAST_PTR);
      O_frame_done  <= frame_done_n;
      O_frame_err   <= frame_err_n;
      O_last_frame  <= last_frame_n;
    end
  end

  // Burst buffer: simple dual-port RAM, write from packer, registered read.
  always_ff @(posedge I_clk) begin
    if (word_valid) burst_mem[wr_ptr] <= word_data;
  end

  // Read address looks one word ahead so the next word is on O_wr_data after a handshake.
  always_ff @(posedge I_clk) begin
    O_wr_data <= burst_mem[rd_ptr_n];
  end

endmodule

// File: tb/tb_cmos_frame_writer.sv
// Scoreboard bench for cmos_frame_writer on a reduced 64x2 frame, 4-word bursts.
// The driver feeds a frame-level reference model; a monitor checks every handshake.
module tb_cmos_frame_writer;

  localparam int H_RES  = 64;
  localparam int V_RES  = 2;
  localparam int BW     = 4;
  localparam int AW     = 28;
  localparam int FS     = 21;
  localparam int PPB    = BW * 8;
  localparam int PPF    = H_RES * V_RES;

  logic           I_clk = 1'b0;
  logic           I_rst, I_calib_done, I_pix_valid, I_pix_sof;
  logic [15:0]    I_pix_data;
  logic           O_pix_ready, I_cmd_ready, O_cmd_en;
  logic [2:0]     O_cmd;
  logic [AW-1:0]  O_addr;
  logic [5:0]     O_app_burst_number;
  logic           I_wr_data_rdy, O_wr_data_en, O_wr_data_end;
  logic [127:0]   O_wr_data;
  logic [15:0]    O_wr_data_mask;
  logic           O_frame_done, O_frame_err;
  logic [1:0]     O_last_frame;

  cmos_frame_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .BURST_WORDS(BW), .ADDR_WIDTH(AW), .FRAME_SHIFT(FS)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_calib_done(I_calib_done),
    .I_pix_valid(I_pix_valid), .I_pix_data(I_pix_data), .I_pix_sof(I_pix_sof),
    .O_pix_ready(O_pix_ready), .I_cmd_ready(I_cmd_ready), .O_cmd(O_cmd),
    .O_cmd_en(O_cmd_en), .O_addr(O_addr), .O_app_burst_number(O_app_burst_number),
    .I_wr_data_rdy(I_wr_data_rdy), .O_wr_data(O_wr_data), .O_wr_data_en(O_wr_data_en),
    .O_wr_data_end(O_wr_data_end), .O_wr_data_mask(O_wr_data_mask),
    .O_frame_done(O_frame_done), .O_last_frame(O_last_frame), .O_frame_err(O_frame_err)
  );

  always #5 I_clk = ~I_clk;

  typedef struct packed { logic [127:0] d; logic last; } wexp_t;
  typedef struct packed { logic is_done; logic [1:0] bufi; } ev_t;

  logic [AW-1:0] cmd_q [$];
  wexp_t         word_q [$];
  ev_t           ev_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with no matching expectation", name);
  endtask

  // Reference model: frame-level bookkeeping on accepted pixels.
  int          m_buf = 0;
  bit          m_in  = 0;
  int          m_cnt = 0;
  logic [15:0] m_pix [PPB];

  task automatic model_accept(input logic [15:0] d, input logic s);
    if (s) begin
      if (m_in) begin
        ev_q.push_back('{is_done: 1'b0, bufi: 2'(m_buf)});
        m_buf = (m_buf + 1) % 3;
      end
      m_in  = 1;
      m_cnt = 0;
    end
    if (!m_in) return;
    m_pix[m_cnt % PPB] = d;
    m_cnt++;
    if (m_cnt % PPB == 0) begin
      cmd_q.push_back(AW'((m_buf << FS) + (m_cnt / PPB - 1) * PPB));
      for (int w = 0; w < BW; w++) begin
        logic [127:0] wd;
        for (int k = 0; k < 8; k++) wd[16*k +: 16] = m_pix[w*8 + k];
        word_q.push_back('{d: wd, last: (w == BW - 1)});
      end
    end
    if (m_cnt == PPF) begin
      ev_q.push_back('{is_done: 1'b1, bufi: 2'(m_buf)});
      m_buf = (m_buf + 1) % 3;
      m_in  = 0;
    end
  endtask

  task automatic model_reset();
    cmd_q.delete();
    word_q.delete();
    ev_q.delete();
    m_buf = 0;
    m_in  = 0;
    m_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the pixel is accepted.
  task automatic send_pix(input logic [15:0] d, input logic s, input bit gaps);
    int   guard;
    logic acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      I_pix_valid = 1'b0;
      @(negedge I_clk);
    end
    I_pix_valid = 1'b1;
    I_pix_data  = d;
    I_pix_sof   = s;
    guard = 0;
    do begin
      acc = O_pix_ready;
      @(negedge I_clk);
      guard++;
    end while (!acc && guard < 5000);
    I_pix_valid = 1'b0;
    I_pix_sof   = 1'b0;
    if (acc) model_accept(d, s);
    else chk("pix_accept_timeout", {127'd0, acc}, 128'd1);
  endtask

  task automatic send_frame(input int n, input bit counting, input bit gaps);
    for (int i = 0; i < n; i++)
      send_pix(counting ? 16'(i) : 16'($urandom), (i == 0), gaps);
  endtask

  // Monitor: drives the memory-side ready inputs and scores every handshake.
  bit            mon_en      = 0;
  int            cmd_wait    = 0;
  int            stall_len   = 10;
  int            data_hs_cnt = 0;
  bit            prev_stall  = 0;
  logic [AW-1:0] prev_addr   = '0;

  initial begin
    I_cmd_ready   = 1'b0;
    I_wr_data_rdy = 1'b0;
    forever begin
      @(negedge I_clk);
      if (O_cmd_en) begin
        I_cmd_ready = (cmd_wait >= stall_len);
        cmd_wait++;
      end else begin
        cmd_wait    = 0;
        I_cmd_ready = 1'($urandom_range(0, 1));
      end
      I_wr_data_rdy = ($urandom_range(0, 9) < 6);
      #1;
      if (!mon_en) begin
        prev_stall = 0;
        continue;
      end
      if (O_cmd_en || O_wr_data_en) chk("pix_ready_low_in_burst", O_pix_ready, 0);
      if (prev_stall) begin
        chk("cmd_en_held", O_cmd_en, 1);
        chk("addr_held", O_addr, prev_addr);
      end
      prev_stall = O_cmd_en && !I_cmd_ready;
      prev_addr  = O_addr;
      if (O_cmd_en && I_cmd_ready) begin
        if (cmd_q.size() == 0) fail_now("cmd_unexpected");
        else chk("cmd_addr", O_addr, cmd_q.pop_front());
        stall_len = $urandom_range(0, 3);
      end
      if (O_wr_data_en && I_wr_data_rdy) begin
        data_hs_cnt++;
        if (word_q.size() == 0) fail_now("data_unexpected");
        else begin
          wexp_t w;
          w = word_q.pop_front();
          chk("wr_data", O_wr_data, w.d);
          chk("wr_data_end", O_wr_data_end, w.last);
        end
      end
      if (O_frame_done) begin
        if (ev_q.size() == 0) fail_now("frame_done_unexpected");
        else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("frame_done_kind", 1'b1, e.is_done);
          chk("last_frame", O_last_frame, e.bufi);
        end
      end
      if (O_frame_err) begin
        if (ev_q.size() == 0) fail_now("frame_err_unexpected");
        else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("frame_err_kind", 1'b0, e.is_done);
        end
      end
    end
  end

  initial begin
    int cnt0;
    I_rst        = 1'b1;
    I_calib_done = 1'b1;
    I_pix_valid  = 1'b0;
    I_pix_sof    = 1'b0;
    I_pix_data   = 16'h0;
    repeat (3) @(negedge I_clk);
    chk("rst_pix_ready", O_pix_ready, 0);
    chk("rst_cmd_en", O_cmd_en, 0);
    chk("rst_addr", O_addr, 0);
    chk("rst_wr_en", O_wr_data_en, 0);
    chk("rst_wr_end", O_wr_data_end, 0);
    chk("rst_frame_done", O_frame_done, 0);
    chk("rst_frame_err", O_frame_err, 0);
    chk("rst_last_frame", O_last_frame, 2);
    chk("cmd_code", O_cmd, 0);
    chk("burst_number", O_app_burst_number, BW - 1);
    chk("data_mask", O_wr_data_mask, 0);
    I_rst = 1'b0;
    @(negedge I_clk);
    chk("idle_pix_ready", O_pix_ready, 1);
    mon_en = 1;

    // Counting pixels 0..127, no gaps, first command stalled 10 cycles.
    send_frame(PPF, 1'b1, 1'b0);
    // Three more frames with random data, gaps and leading non-SOF junk.
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 3; j++) send_pix(16'($urandom), 1'b0, 1'b0);
      send_frame(PPF, 1'b0, 1'b1);
    end
    // Frame aborted by an SOF at pixel 40, followed by a full frame.
    send_frame(40, 1'b0, 1'b1);
    send_frame(PPF, 1'b0, 1'b1);

    // Reset while the third word of a burst is pending.
    cnt0 = data_hs_cnt;
    send_frame(PPB, 1'b0, 1'b0);
    for (int i = 0; i < 500 && data_hs_cnt < cnt0 + 2; i++) @(negedge I_clk);
    chk("reach_word2", {127'd0, (data_hs_cnt >= cnt0 + 2)}, 128'd1);
    mon_en = 0;
    I_rst  = 1'b1;
    @(negedge I_clk);
    chk("rst_mid_cmd_en", O_cmd_en, 0);
    chk("rst_mid_wr_en", O_wr_data_en, 0);
    chk("rst_mid_wr_end", O_wr_data_end, 0);
    chk("rst_mid_pix_ready", O_pix_ready, 0);
    chk("rst_mid_frame_done", O_frame_done, 0);
    chk("rst_mid_frame_err", O_frame_err, 0);
    I_rst = 1'b0;
    model_reset();
    @(negedge I_clk);
    mon_en = 1;
    send_frame(PPF, 1'b0, 1'b1);

    for (int i = 0; i < 3000 && (cmd_q.size() != 0 || word_q.size() != 0 || ev_q.size() != 0); i++)
      @(negedge I_clk);
    chk("drain_cmd_q", cmd_q.size(), 0);
    chk("drain_word_q", word_q.size(), 0);
    chk("drain_ev_q", ev_q.size(), 0);
    repeat (5) @(negedge I_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
